// File: rtl/hq_stream_sequencer_if.sv
// rtl/hq_stream_sequencer_if.sv - H load port and multiplier-side signals for hq_stream_sequencer
interface hq_stream_sequencer_if #(
    parameter int N = 16
);
    logic                load_valid;
    logic                load_ready;
    logic signed [N-1:0] load_r;
    logic signed [N-1:0] load_i;
    logic                mm_start;
    logic signed [N-1:0] mm_h_r;
    logic signed [N-1:0] mm_h_i;
    logic                mm_out_valid;
    logic                mm_all_done;

    // master: estimate buffer / multiplier side; slave: the sequencer
    modport master (
        output load_valid, load_r, load_i, mm_out_valid, mm_all_done,
        input  load_ready, mm_start, mm_h_r, mm_h_i
    );

    modport slave (
        input  load_valid, load_r, load_i, mm_out_valid, mm_all_done,
        output load_ready, mm_start, mm_h_r, mm_h_i
    );
endinterface

// File: rtl/hq_stream_sequencer.sv
// rtl/hq_stream_sequencer.sv - loads a 4x4 complex H, streams it to the H-by-S multiplier, checks the batch
module hq_stream_sequencer #(
    parameter int N             = 16,
    parameter int NUM_Q         = 16,
    parameter int EXP_OUTS      = 128,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hq_stream_sequencer_if.slave  bus,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            out_count
);
    localparam int QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;
    localparam int CW = QW + 5;
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = {QW'(NUM_Q - 1), 5'b11111};

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      load_cnt_q, load_cnt_d;
    logic [CW-1:0]   stream_cnt_q, stream_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            mm_start_q, mm_start_d;
    logic [7:0]      out_count_q, out_count_d;
    logic [7:0]      cnt_inc;
    logic            h_loaded;
    logic            load_fire;
    logic [3:0]      h_idx;

    logic signed [N-1:0] h_r_q [16];
    logic signed [N-1:0] h_i_q [16];

    assign h_loaded       = load_cnt_q[4];
    assign bus.load_ready = (state_q == S_IDLE) && !h_loaded;
    assign load_fire      = bus.load_valid && bus.load_ready;

    // counter layout is {q, i, j, k}: k fastest, so element index is {i, k}
    assign h_idx      = {stream_cnt_q[4:3], stream_cnt_q[1:0]};
    assign bus.mm_h_r = (state_q == S_STREAM) ? h_r_q[h_idx] : '0;
    assign bus.mm_h_i = (state_q == S_STREAM) ? h_i_q[h_idx] : '0;

    assign bus.mm_start = mm_start_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign out_count    = out_count_q;

    always_ff @(posedge clk) begin
        if (load_fire) begin
            h_r_q[load_cnt_q[3:0]] <= bus.load_r;
            h_i_q[load_cnt_q[3:0]] <= bus.load_i;
        end
    end

    always_comb begin
        cnt_inc = out_count_q;
        if (bus.mm_out_valid && busy_q && (out_count_q != 8'hFF)) begin
            cnt_inc = out_count_q + 8'd1;
        end

        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        stream_cnt_d = stream_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        mm_start_d   = 1'b0;
        out_count_d  = cnt_inc;

        case (state_q)
            S_IDLE: begin
                if (load_fire) begin
                    load_cnt_d = load_cnt_q + 5'd1;
                end
                if (go && h_loaded) begin
                    state_d     = S_START;
                    error_d     = 1'b0;
                    out_count_d = 8'd0;
                    busy_d      = 1'b1;
                    mm_start_d  = 1'b1;
                end
            end
            S_START: begin
                state_d      = S_STREAM;
                stream_cnt_d = '0;
            end
            S_STREAM: begin
                stream_cnt_d = stream_cnt_q + CW'(1);
                if (bus.mm_all_done) begin
                    error_d = 1'b1;
                end
                if (stream_cnt_q == LAST_CNT) begin
                    state_d   = S_DRAIN;
                    tmo_cnt_d = '0;
                end
            end
            S_DRAIN: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (bus.mm_all_done || (tmo_cnt_q == TW'(DRAIN_TIMEOUT - 1))) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // the count checked includes a valid landing in this exit cycle
                    if (!bus.mm_all_done || (cnt_inc != 8'(EXP_OUTS))) begin
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                load_cnt_d = 5'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= 5'd0;
            stream_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            mm_start_q   <= 1'b0;
            out_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            stream_cnt_q <= stream_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            mm_start_q   <= mm_start_d;
            out_count_q  <= out_count_d;
        end
    end
endmodule

// File: doc/hq_stream_sequencer.md
Name: hq_stream_sequencer

Overview:
- Sequences the complex H-by-S matrix multiplier for one full 16-matrix batch.
- Captures one 4x4 complex H matrix through a valid/ready load port and issues the multiplier's start pulse.
- Streams H elements in exactly the order the multiplier's internal q/i/j/k counters expect, then checks the output stream and reports done or error.
- Sits between the channel-estimate buffer and the multiplier.

Parameters:
- N, 16, width of each real/imaginary H sample (signed fixed point).
- NUM_Q, 16, number of S matrices per batch; fixed by the multiplier's coefficient table.
- EXP_OUTS, 128, expected multiplier output-valid count per batch (NUM_Q * 4 rows * 2 columns).
- DRAIN_TIMEOUT, 64, maximum cycles to wait for the multiplier's all-done after streaming ends.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  H element valid.
- load_ready  out  1  sequencer accepts an H element.
- load_r  in  N  H element, real part; row-major order, index = 4*i + k.
- load_i  in  N  H element, imaginary part.
- go  in  1  start batch; honoured only in IDLE with all 16 H elements loaded.
- busy  out  1  high from go acceptance until done.
- done  out  1  one-cycle pulse at batch completion.
- error  out  1  sticky; cleared on the next accepted go.
- mm_start  out  1  one-cycle start pulse to the multiplier.
- mm_h_r  out  N  H real part to the multiplier.
- mm_h_i  out  N  H imaginary part to the multiplier.
- mm_out_valid  in  1  multiplier Hq output valid.
- mm_all_done  in  1  multiplier all-16-matrices-done flag.
- out_count  out  8  multiplier output-valid count for the current batch.

Behaviour:
- Reset values: load_ready=1, busy=0, done=0, error=0, mm_start=0, mm_h_r=0, mm_h_i=0, out_count=0. Load counter, q/i/j/k counters and state (IDLE) also clear; the register file need not reset.
- Load phase (IDLE only):
  - A handshake (load_valid & load_ready) writes regfile[load_cnt] and increments load_cnt.
  - At load_cnt=16, h_loaded=1 and load_ready=0.
  - load_ready=0 in every other state.
- go with h_loaded=0 is ignored: no state change, no error.
- States:
  - IDLE: accepted go -> START. error clears, out_count clears, busy=1.
  - START: mm_start=1 for exactly this cycle -> STREAM. All counters are 0.
  - STREAM:
    - mm_h = regfile[4*i+k], combinational from registered counters, valid from the cycle after START.
    - Counter nesting: k increments every cycle; k wraps 3->0 and advances j; j wraps 1->0 and advances i; i wraps 3->0 and advances q.
    - Leave to DRAIN after the cycle with q=NUM_Q-1, i=3, j=1, k=3: 512 cycles total.
  - DRAIN: mm_h driven 0; timeout counter runs.
    - mm_all_done -> DONE.
    - DRAIN_TIMEOUT cycles without it -> error=1 -> DONE.
  - DONE: done=1 for one cycle, busy=0, h_loaded=0, load_cnt=0 -> IDLE.
- out_count:
  - Increments on every mm_out_valid while busy, saturating at 255.
  - Compared at DRAIN exit: the value including a valid in the exit cycle must equal EXP_OUTS, otherwise error=1.
- Simultaneous events:
  - mm_all_done during STREAM: error=1, streaming continues to completion.
  - go while busy: ignored.
  - load_valid outside IDLE: not accepted.
- Reset mid-operation: immediate return to IDLE with all outputs at their reset values. The loaded matrix is invalidated (h_loaded=0).

Test Plan:
- Load regfile[n] = (n, -n) for n=0..15, then pulse go. Required: mm_start high exactly one cycle. The next cycles present (0,0),(1,-1),(2,-2),(3,-3),(0,0),(1,-1),(2,-2),(3,-3),(4,-4),... Cycle 512 after START presents (15,-15).
- Full batch against the real multiplier. Required: out_count=128, done pulses once, error=0, busy low after done.
- go after only 10 loads. Required: no mm_start, busy stays 0. After 6 more loads, go starts the batch normally.
- Multiplier model that never asserts mm_all_done. Required: error=1 and done pulse exactly DRAIN_TIMEOUT cycles after STREAM ends.
- Model emitting only 127 valids before mm_all_done. Required: error=1 at done. A following correct batch clears error on go.
- rst_n low at STREAM cycle 200. Required: mm_h=0, busy=0, load_ready=1 asynchronously. Subsequent go without reload is ignored.
